register_write_arbiter: RTL
===========================

// Module: register_write_arbiter
// PURPOSE
//   Owns the single write port of register_unit. After reset (or on i_clear) it sequences a
//   zero-sweep of x1..x31, since block-RAM register storage has no reset. In normal operation
//   it shares the write port between the writeback stage and the debug module via valid/ready.
//   Sits between WB/debug and register_unit; o_we/o_rd/o_rd_data drive i_we/i_rd/i_rd_data.
// PARAMETERS
//   INIT_ON_RESET     1   1: enter INIT after reset; 0: enter RUN directly
//   DBG_STARVE_LIMIT  4   consecutive cycles debug may be blocked by WB before it is forced in (1..15)
// PORTS
//   i_clk        in   1   clock, all state on posedge
//   i_rst_n      in   1   asynchronous active-low reset
//   i_clear      in   1   single-cycle pulse: restart zero-sweep (honoured in RUN only)
//   i_wb_valid   in   1   writeback write request
//   o_wb_ready   out  1   writeback request accepted this cycle (combinational)
//   i_wb_rd      in   5   writeback destination register
//   i_wb_data    in   32  writeback data
//   i_dbg_valid  in   1   debug write request
//   o_dbg_ready  out  1   debug request accepted this cycle (combinational)
//   i_dbg_rd     in   5   debug destination register
//   i_dbg_data   in   32  debug data
//   o_we         out  1   register_unit write enable (registered)
//   o_rd         out  5   register_unit write address (registered)
//   o_rd_data    out  32  register_unit write data (registered)
//   o_init_busy  out  1   high while in INIT (registered)
// BEHAVIOUR
//   Reset: o_we=0, o_rd=0, o_rd_data=0, starve_cnt=0, sweep_cnt=1;
//     state=INIT, o_init_busy=1 if INIT_ON_RESET, else state=RUN, o_init_busy=0.
//   FSM INIT:
//     each posedge loads o_we=1, o_rd=sweep_cnt, o_rd_data=0, sweep_cnt++.
//     When sweep_cnt==31 is issued -> RUN, sweep_cnt=1, o_init_busy=0.
//     Exactly 31 write cycles, x1 first, x31 last, no gaps.
//     Both readies are 0 throughout INIT; i_clear is ignored.
//   FSM RUN:
//     i_clear=1 -> INIT next cycle, o_init_busy=1 next cycle. Both readies are 0 in the
//     i_clear cycle (clear wins over requests); o_we=0 that cycle.
//   Arbitration in RUN (i_clear=0), combinational:
//     force = i_dbg_valid && starve_cnt>=DBG_STARVE_LIMIT
//     o_dbg_ready = i_dbg_valid && (!i_wb_valid || force)
//     o_wb_ready  = i_wb_valid && !o_dbg_ready
//     At most one grant per cycle. Ready never asserts without its valid.
//   starve_cnt:
//     +1 (saturating at 15) when i_dbg_valid && o_wb_ready.
//     Cleared when o_dbg_ready, or when !i_dbg_valid.
//   Write issue, registered, 1-cycle latency:
//     a handshake on cycle N gives o_we=1, o_rd=rd, o_rd_data=data on cycle N+1.
//     No handshake: o_we=0, o_rd/o_rd_data hold their previous values.
//   rd==0: the request is accepted (ready=1), but o_we=0 next cycle (write dropped).
//     It counts as a grant for starve_cnt purposes.
//   Requesters must hold valid/rd/data stable until ready; the arbiter keeps no request buffer.
//   Async reset mid-sweep or mid-write: all state returns to reset values immediately. A sweep
//     restarts at x1 (if INIT_ON_RESET); an in-flight write is lost.
// TESTING
//   1 Reset release, INIT_ON_RESET=1, no requests -> o_we=1 for 31 consecutive cycles,
//     o_rd=1..31, data 0; then o_init_busy=0 and readies follow valids.
//   2 RUN, wb_valid rd=5 data=0xDEADBEEF -> wb_ready same cycle; next cycle o_we=1,
//     o_rd=5, o_rd_data=0xDEADBEEF.
//   3 wb_valid and dbg_valid held high continuously, LIMIT=4 -> grants follow the pattern
//     WB,WB,WB,WB,DBG repeating; starve_cnt returns to 0 after each DBG grant.
//   4 dbg_valid rd=0 data=0x1234 alone -> dbg_ready=1; next cycle o_we=0.
//   5 i_clear pulsed together with wb_valid -> wb_ready=0; 31-cycle sweep follows;
//     the held wb request is granted on the first RUN cycle.
//   6 i_rst_n low during sweep at x17 -> outputs reset asynchronously; after release the
//     sweep restarts at x1.

Source files
------------

// File: rtl/register_write_arbiter.sv
// Write-port owner for register_unit: zero-sweeps x1..x31 after reset or clear,
// then arbitrates WB and debug writes with a starvation guard for debug.
module register_write_arbiter #(
    parameter bit INIT_ON_RESET    = 1'b1,
    parameter int DBG_STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_wb_valid,
    output logic        o_wb_ready,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_dbg_valid,
    output logic        o_dbg_ready,
    input  logic [4:0]  i_dbg_rd,
    input  logic [31:0] i_dbg_data,
    output logic        o_we,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rd_data,
    output logic        o_init_busy
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(DBG_STARVE_LIMIT);
    localparam logic [3:0] STARVE_MAX   = 4'd15;
    localparam state_t     RESET_STATE  = INIT_ON_RESET ? ST_INIT : ST_RUN;

    state_t      r_state;
    logic [4:0]  r_sweep_cnt;
    logic [3:0]  r_starve_cnt;
    logic        r_we;
    logic [4:0]  r_rd;
    logic [31:0] r_rd_data;
    logic        r_init_busy;

    logic        w_arb_en;
    logic        w_force;
    logic        w_dbg_ready;
    logic        w_wb_ready;

    // Clear takes priority over any pending request in the cycle it arrives.
    assign w_arb_en    = (r_state == ST_RUN) && !i_clear;
    assign w_force     = i_dbg_valid && (r_starve_cnt >= STARVE_LIMIT);
    assign w_dbg_ready = w_arb_en && i_dbg_valid && (!i_wb_valid || w_force);
    assign w_wb_ready  = w_arb_en && i_wb_valid && !w_dbg_ready;

    assign o_wb_ready  = w_wb_ready;
    assign o_dbg_ready = w_dbg_ready;
    assign o_we        = r_we;
    assign o_rd        = r_rd;
    assign o_rd_data   = r_rd_data;
    assign o_init_busy = r_init_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= RESET_STATE;
            r_sweep_cnt  <= 5'd1;
            r_starve_cnt <= 4'd0;
            r_we         <= 1'b0;
            r_rd         <= 5'd0;
            r_rd_data    <= 32'd0;
            r_init_busy  <= INIT_ON_RESET;
        end else begin
            if (w_dbg_ready || !i_dbg_valid) begin
                r_starve_cnt <= 4'd0;
            end else if (w_wb_ready && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            case (r_state)
                ST_INIT: begin
                    r_we      <= 1'b1;
                    r_rd      <= r_sweep_cnt;
                    r_rd_data <= 32'd0;
                    if (r_sweep_cnt == 5'd31) begin
                        r_state     <= ST_RUN;
                        r_sweep_cnt <= 5'd1;
                        r_init_busy <= 1'b0;
                    end else begin
                        r_sweep_cnt <= r_sweep_cnt + 5'd1;
                    end
                end
                default: begin
                    if (i_clear) begin
                        r_state     <= ST_INIT;
                        r_sweep_cnt <= 5'd1;
                        r_init_busy <= 1'b1;
                        r_we        <= 1'b0;
                    end else if (w_dbg_ready) begin
                        // x0 writes are accepted but never reach the register file.
                        r_we <= (i_dbg_rd != 5'd0);
                        if (i_dbg_rd != 5'd0) begin
                            r_rd      <= i_dbg_rd;
                            r_rd_data <= i_dbg_data;
                        end
                    end else if (w_wb_ready) begin
                        r_we <= (i_wb_rd != 5'd0);
                        if (i_wb_rd != 5'd0) begin
                            r_rd      <= i_wb_rd;
                            r_rd_data <= i_wb_data;
                        end
                    end else begin
                        r_we <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
